// File: rtl/jtag_interface.sv
// IEEE 1149.1-style TAP controller with a 5-bit IR, BYPASS, optional IDCODE and one user data register.
// Define IDCODE_EN to build the 32-bit IDCODE register; without it, reset and Test-Logic-Reset select BYPASS.
module jtag_interface #(
  parameter int          IR_WIDTH     = 5,
  parameter int          DR_WIDTH     = 16,
  parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001
) (
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  input  logic                TRST_N,
  output logic                TDO_EN,
  output logic [DR_WIDTH-1:0] USER_DATA,
  output logic [3:0]          TAP_STATE
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET   = '1;
`endif

  // A device ID with bit 0 clear would be read by a debugger as a BYPASS register.
  if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
    $error("IDCODE_VALUE bit 0 must be 1");
  end

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                bypass_q, bypass_d;
  logic [DR_WIDTH-1:0] user_shift_q, user_shift_d;
  logic [DR_WIDTH-1:0] user_data_q, user_data_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                sel_user;
  logic                sel_idcode;
  logic                idcode_lsb;

  assign sel_user = (ir_q == IR_USER);

`ifdef IDCODE_EN
  logic [31:0] idcode_shift_q, idcode_shift_d;

  assign sel_idcode = (ir_q == IR_IDCODE);
  assign idcode_lsb = idcode_shift_q[0];

  always_comb begin
    idcode_shift_d = idcode_shift_q;
    if (sel_idcode && state_q == CAP_DR) idcode_shift_d = IDCODE_VALUE;
    else if (sel_idcode && state_q == SH_DR) idcode_shift_d = {TDI, idcode_shift_q[31:1]};
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) idcode_shift_q <= '0;
    else         idcode_shift_q <= idcode_shift_d;
  end
`else
  assign sel_idcode = 1'b0;
  assign idcode_lsb = 1'b0;
`endif

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PA_DR;
      PA_DR:  state_d = TMS ? EX2_DR : PA_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PA_IR;
      PA_IR:  state_d = TMS ? EX2_IR : PA_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Capture, shift and update act on the edge that leaves the corresponding state.
  always_comb begin
    ir_shift_d   = ir_shift_q;
    ir_d         = ir_q;
    bypass_d     = bypass_q;
    user_shift_d = user_shift_q;
    user_data_d  = user_data_q;
    unique case (state_q)
      TLR:    ir_d       = IR_RESET;
      CAP_IR: ir_shift_d = IR_CAPTURE;
      SH_IR:  ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
      UPD_IR: ir_d       = ir_shift_q;
      CAP_DR: begin
        if (sel_user)         user_shift_d = user_data_q;
        else if (!sel_idcode) bypass_d     = 1'b0;
      end
      SH_DR: begin
        if (sel_user)         user_shift_d = {TDI, user_shift_q[DR_WIDTH-1:1]};
        else if (!sel_idcode) bypass_d     = TDI;
      end
      UPD_DR: if (sel_user) user_data_d = user_shift_q;
      default: ;
    endcase
  end

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_en_d = 1'b1;
      if (sel_user)        tdo_d = user_shift_q[0];
      else if (sel_idcode) tdo_d = idcode_lsb;
      else                 tdo_d = bypass_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q      <= TLR;
      ir_shift_q   <= '0;
      ir_q         <= IR_RESET;
      bypass_q     <= 1'b0;
      user_shift_q <= '0;
      user_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ir_shift_q   <= ir_shift_d;
      ir_q         <= ir_d;
      bypass_q     <= bypass_d;
      user_shift_q <= user_shift_d;
      user_data_q  <= user_data_d;
    end
  end

  // TDO launches on the falling edge so the external sampler sees it stable at the next rising edge.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign TDO       = tdo_q;
  assign TDO_EN    = tdo_en_q;
  assign USER_DATA = user_data_q;
  assign TAP_STATE = state_q;

endmodule

// File: tb/tb_jtag_interface.sv
// Scoreboard bench for jtag_interface: scan tasks push expected TDO bits, a monitor pops and compares them.
module tb_jtag_interface;

  localparam int          IR_W = 5;
  localparam int          DR_W = 16;
  localparam logic [31:0] IDC  = 32'h1234_5001;
`ifdef IDCODE_EN
  localparam bit          IDC_EN = 1'b1;
`else
  localparam bit          IDC_EN = 1'b0;
`endif
  localparam logic [IR_W-1:0] IR_RST = IDC_EN ? 5'b00001 : 5'b11111;

  logic            tck = 1'b0;
  logic            tms, tdi, trst_n;
  logic            tdo, tdo_en;
  logic [DR_W-1:0] user_data;
  logic [3:0]      tap_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 1'b1;
  bit exp_q[$];

  // Reference model: current instruction and user register contents.
  logic [IR_W-1:0] m_ir;
  logic [DR_W-1:0] m_user;

  typedef struct { bit tms; logic [3:0] st; } walk_t;
  walk_t walk[$];

  jtag_interface #(.IR_WIDTH(IR_W), .DR_WIDTH(DR_W), .IDCODE_VALUE(IDC)) dut (
    .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo), .TRST_N(trst_n),
    .TDO_EN(tdo_en), .USER_DATA(user_data), .TAP_STATE(tap_state)
  );

  always #10 tck = ~tck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: TDO is stable between the falling edge and the next rising edge.
  always @(negedge tck) begin
    #5;
    if (mon_on) begin
      if (tdo_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tdo_unexpected: TDO_EN high with no expected bit at %0t", $time);
        end else begin
          check("tdo_bit", {31'b0, tdo}, {31'b0, exp_q.pop_front()});
        end
      end else begin
        check("tdo_idle", {31'b0, tdo}, 32'h0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dr_width(input logic [IR_W-1:0] ir);
    if (IDC_EN && ir == 5'b00001) return 32;
    if (ir == 5'b00010) return DR_W;
    return 1;
  endfunction

  function automatic logic [31:0] dr_capture(input logic [IR_W-1:0] ir);
    if (IDC_EN && ir == 5'b00001) return IDC;
    if (ir == 5'b00010) return {16'b0, m_user};
    return 32'h0;
  endfunction

  task automatic step(input bit tms_v, input bit tdi_v, input bit push, input bit eb);
    @(negedge tck);
    #2;
    if (push) exp_q.push_back(eb);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge tck);
    #1;
  endtask

  task automatic nav(input bit tms_v);
    step(tms_v, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse between edges; ends parked in Run-Test/Idle.
  task automatic trst_pulse();
    @(negedge tck);
    #2;
    tms    = 1'b1;
    trst_n = 1'b0;
    #1;
    m_ir   = IR_RST;
    m_user = '0;
    check("trst_state", {28'b0, tap_state}, 32'hF);
    check("trst_user", {16'b0, user_data}, 32'h0);
    check("trst_tdo_en", {31'b0, tdo_en}, 32'h0);
    @(posedge tck);
    #3;
    trst_n = 1'b1;
    @(posedge tck);
    #1;
    check("trst_hold_tlr", {28'b0, tap_state}, 32'hF);
    nav(1'b0);
    check("trst_to_rti", {28'b0, tap_state}, 32'hC);
  endtask

  // Scan n bits of data (LSB first) through IR or DR starting from Run-Test/Idle.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] data,
                      input int pause_at, input bit to_tlr, input int abort_at);
    bit          stream[$];
    int          w;
    logic [31:0] cap;
    logic [31:0] val;
    bit          b;
    bit          ex;
    if (is_ir) begin
      w   = IR_W;
      cap = 32'h1;
    end else begin
      w   = dr_width(m_ir);
      cap = dr_capture(m_ir);
    end
    for (int i = 0; i < w; i++) stream.push_back(cap[i]);
    nav(1'b1);
    if (is_ir) nav(1'b1);
    nav(1'b0);
    nav(1'b0);
    if (is_ir) check("enter_shift_ir", {28'b0, tap_state}, 32'hA);
    else       check("enter_shift_dr", {28'b0, tap_state}, 32'h2);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        trst_pulse();
        return;
      end
      b = stream.pop_front();
      stream.push_back(data[i]);
      ex = (i == n - 1) || (i == pause_at);
      step(ex, data[i], 1'b1, b);
      if (ex && i != n - 1) begin
        nav(1'b0);
        nav(1'b0);
        nav(1'b1);
        nav(1'b0);
      end
    end
    val = '0;
    for (int i = 0; i < w; i++) val[i] = stream[i];
    nav(1'b1);
    if (is_ir) m_ir = val[IR_W-1:0];
    else if (m_ir == 5'b00010) m_user = val[DR_W-1:0];
    if (to_tlr) begin
      nav(1'b1);
      nav(1'b1);
      nav(1'b1);
      m_ir = IR_RST;
      check("five_ones_tlr", {28'b0, tap_state}, 32'hF);
      nav(1'b0);
    end else begin
      nav(1'b0);
    end
    check("scan_end_rti", {28'b0, tap_state}, 32'hC);
    check("user_data", {16'b0, user_data}, {16'b0, m_user});
  endtask

  initial begin
    logic [63:0] d;
    int          op, n, p;
    tms    = 1'b1;
    tdi    = 1'b0;
    trst_n = 1'b0;
    m_ir   = IR_RST;
    m_user = '0;
    #35;
    trst_n = 1'b1;
    #1;
    check("reset_state", {28'b0, tap_state}, 32'hF);
    check("reset_tdo", {31'b0, tdo}, 32'h0);
    check("reset_tdo_en", {31'b0, tdo_en}, 32'h0);
    check("reset_user", {16'b0, user_data}, 32'h0);

    // Every transition of the TAP graph, TDI held high, ending in Test-Logic-Reset.
    walk = '{'{1'b1,4'hF}, '{1'b0,4'hC}, '{1'b0,4'hC}, '{1'b1,4'h7}, '{1'b1,4'h4},
             '{1'b0,4'hE}, '{1'b1,4'h9}, '{1'b1,4'hD}, '{1'b0,4'hC}, '{1'b1,4'h7},
             '{1'b1,4'h4}, '{1'b0,4'hE}, '{1'b0,4'hA}, '{1'b0,4'hA}, '{1'b1,4'h9},
             '{1'b0,4'hB}, '{1'b0,4'hB}, '{1'b1,4'h8}, '{1'b1,4'hD}, '{1'b1,4'h7},
             '{1'b1,4'h4}, '{1'b0,4'hE}, '{1'b0,4'hA}, '{1'b1,4'h9}, '{1'b0,4'hB},
             '{1'b1,4'h8}, '{1'b0,4'hA}, '{1'b1,4'h9}, '{1'b1,4'hD}, '{1'b1,4'h7},
             '{1'b0,4'h6}, '{1'b1,4'h1}, '{1'b1,4'h5}, '{1'b0,4'hC}, '{1'b1,4'h7},
             '{1'b0,4'h6}, '{1'b0,4'h2}, '{1'b0,4'h2}, '{1'b1,4'h1}, '{1'b0,4'h3},
             '{1'b0,4'h3}, '{1'b1,4'h0}, '{1'b0,4'h2}, '{1'b1,4'h1}, '{1'b0,4'h3},
             '{1'b1,4'h0}, '{1'b1,4'h5}, '{1'b1,4'h7}, '{1'b1,4'h4}, '{1'b1,4'hF}};
    mon_on = 1'b0;
    foreach (walk[i]) begin
      step(walk[i].tms, 1'b1, 1'b0, 1'b0);
      check("walk_state", {28'b0, tap_state}, {28'b0, walk[i].st});
    end
    mon_on = 1'b1;
    m_ir = IR_RST;
    check("walk_user", {16'b0, user_data}, 32'h0);
    nav(1'b0);

    // 1-bit DR scan leaving Shift-DR with five TMS=1 edges.
    scan(1'b0, 1, 64'h1, -1, 1'b1, -1);
    // IR 00010 emits the 00001 capture value and selects USERDATA.
    scan(1'b1, IR_W, 64'h02, -1, 1'b0, -1);
    scan(1'b0, DR_W, 64'hA5C3, -1, 1'b0, -1);
    check("user_a5c3", {16'b0, user_data}, 32'hA5C3);
    scan(1'b0, DR_W, 64'h3C5A, 5, 1'b0, -1);
    // IDCODE (or BYPASS) straight after reset.
    trst_pulse();
    scan(1'b0, 32, {$urandom, $urandom}, -1, 1'b0, -1);
    // BYPASS: TDI 1,0,1,1 must appear as 0,1,0,1.
    scan(1'b1, IR_W, 64'h00, -1, 1'b0, -1);
    scan(1'b0, 4, 64'hD, -1, 1'b0, -1);
    // Reset mid-scan aborts without update.
    scan(1'b1, IR_W, 64'h02, -1, 1'b0, -1);
    scan(1'b0, DR_W, 64'hFFFF, -1, 1'b0, 7);

    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 9));
      d  = {$urandom, $urandom};
      if (op < 3) begin
        case ($urandom_range(0, 4))
          0: d[4:0] = 5'b00001;
          1, 2: d[4:0] = 5'b00010;
          3: d[4:0] = 5'b00000;
          default: d[4:0] = 5'b11111;
        endcase
        n = ($urandom_range(0, 9) < 7) ? IR_W : int'($urandom_range(1, 9));
        scan(1'b1, n, d, -1, ($urandom_range(0, 9) == 0), -1);
      end else begin
        n = ($urandom_range(0, 9) < 7) ? dr_width(m_ir) : int'($urandom_range(1, 40));
        p = (n > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 2)) : -1;
        scan(1'b0, n, d, p, ($urandom_range(0, 9) == 0),
             (op == 9) ? int'($urandom_range(0, n - 1)) : -1);
      end
    end

    repeat (3) @(posedge tck);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
